// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector: compares the last N accepted bits
// against a runtime-loadable pattern, with overlap select and a saturating match count.
module seq_detect_param #(
  parameter int unsigned          N       = 4,
  parameter logic [N-1:0]         PATTERN = 4'b0001,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       x,
  input  logic                       ovl,
  input  logic                       pat_ld,
  input  logic [N-1:0]               pat_in,
  output logic                       z,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(N+1)-1:0]     fill
);

  localparam int unsigned        FW      = $clog2(N + 1);
  localparam logic [FW-1:0]      FILL_MX = FW'(N);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // MATCH is the only state with bit 2 set, so z comes straight off a flop.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_PARTIAL = 3'b001,
    S_FULL    = 3'b010,
    S_MATCH   = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       pattern_q, pattern_d;
  logic [N-1:0]       window_q, window_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N-1:0]       win_shift;
  logic [FW-1:0]      fill_inc;
  logic               hit;

  // Candidate window/fill for an accepted bit; fill gating keeps stale bits from matching.
  always_comb begin
    win_shift = {window_q[N-2:0], x};
    fill_inc  = (fill_q == FILL_MX) ? FILL_MX : fill_q + FW'(1);
    hit       = (fill_inc == FILL_MX) && (win_shift == pattern_q);
  end

  // Next-state logic: pattern load beats bit acceptance; en=0 holds everything.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    window_d  = window_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;

    if (pat_ld) begin
      pattern_d = pat_in;
      window_d  = '0;
      fill_d    = '0;
      cnt_d     = '0;
      state_d   = S_IDLE;
    end else if (en) begin
      window_d = win_shift;
      if (hit) begin
        state_d = S_MATCH;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        fill_d  = ovl ? FILL_MX : '0;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_MX) ? S_FULL : S_PARTIAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= PATTERN;
      window_q  <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      window_q  <= window_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
    end
  end

  assign z         = state_q[2];
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random stimulus checked
// against a queue-based reference model (two instances, CNT_W=8 and CNT_W=2).
module tb_seq_detect_param;

  localparam int unsigned N     = 4;
  localparam int unsigned FW    = $clog2(N + 1);
  localparam logic [N-1:0] PAT0 = 4'b0001;

  logic          clk = 1'b0;
  logic          rst, en, x, ovl, pat_ld;
  logic [N-1:0]  pat_in;
  logic          z, z2;
  logic [7:0]    match_cnt;
  logic [1:0]    match_cnt2;
  logic [FW-1:0] fill, fill2;

  always #5 clk = ~clk;

  seq_detect_param #(.N(N), .PATTERN(PAT0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .pat_ld(pat_ld),
    .pat_in(pat_in), .z(z), .match_cnt(match_cnt), .fill(fill)
  );

  seq_detect_param #(.N(N), .PATTERN(PAT0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .pat_ld(pat_ld),
    .pat_in(pat_in), .z(z2), .match_cnt(match_cnt2), .fill(fill2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the last accepted bits since the last clear, in arrival order.
  bit           m_q[$];
  int           m_fill;
  bit           m_z;
  int           m_cnt, m_cnt2;
  logic [N-1:0] m_pat;
  logic         ovl_cur;

  task automatic model_clear(input logic [N-1:0] p);
    m_pat = p; m_q.delete(); m_fill = 0; m_z = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_step(input logic i_rst, input logic i_ld, input logic i_en,
                            input logic i_x, input logic i_ovl, input logic [N-1:0] i_pin);
    int val;
    bit hit;
    if (i_rst) model_clear(PAT0);
    else if (i_ld) model_clear(i_pin);
    else if (i_en) begin
      m_q.push_back(i_x);
      if (m_q.size() > N) void'(m_q.pop_front());
      m_fill = (m_fill + 1 > N) ? N : m_fill + 1;
      val = 0;
      foreach (m_q[i]) val = (val << 1) | int'(m_q[i]);
      hit = (m_fill == N) && (val == int'(m_pat));
      m_z = hit;
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!i_ovl) begin
          m_fill = 0;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic i_rst, input logic i_ld, input logic i_en,
                      input logic i_x, input logic i_ovl, input logic [N-1:0] i_pin);
    rst = i_rst; pat_ld = i_ld; en = i_en; x = i_x; ovl = i_ovl; pat_in = i_pin;
    @(posedge clk);
    model_step(i_rst, i_ld, i_en, i_x, i_ovl, i_pin);
    #1;
    check_eq("z",      32'(z),          32'(m_z));
    check_eq("cnt",    32'(match_cnt),  32'(m_cnt));
    check_eq("fill",   32'(fill),       32'(m_fill));
    check_eq("z_w2",   32'(z2),         32'(m_z));
    check_eq("cnt_w2", 32'(match_cnt2), 32'(m_cnt2));
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 1'b0, 1'b1, b, ovl_cur, 4'h0);
  endtask

  task automatic idle(input logic b);
    step(1'b0, 1'b0, 1'b0, b, ovl_cur, 4'h0);
  endtask

  task automatic load(input logic [N-1:0] p);
    step(1'b0, 1'b1, 1'b0, 1'b0, ovl_cur, p);
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    rst = 1'b1; en = 1'b0; x = 1'b0; ovl = 1'b1; pat_ld = 1'b0; pat_in = '0;
    ovl_cur = 1'b1;
    model_clear(PAT0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    check_eq("rst_z", 32'(z), 32'd0);
    check_eq("rst_fill", 32'(fill), 32'd0);

    // Default pattern, overlap on: 0,0,0,0,1 then 1
    bit_in(0); bit_in(0); bit_in(0); bit_in(0);
    check_eq("t1_z_pre", 32'(z), 32'd0);
    bit_in(1);
    check_eq("t1_z", 32'(z), 32'd1);
    check_eq("t1_cnt", 32'(match_cnt), 32'd1);
    bit_in(1);
    check_eq("t1_z_after", 32'(z), 32'd0);

    // 1010 overlapping: hits after bits 4 and 6
    load(4'b1010);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    check_eq("ovl_z4", 32'(z), 32'd1);
    bit_in(1); bit_in(0);
    check_eq("ovl_z6", 32'(z), 32'd1);
    check_eq("ovl_cnt", 32'(match_cnt), 32'd2);

    // 1010 non-overlapping: hits after bits 4 and 8 only
    ovl_cur = 1'b0;
    load(4'b1010);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    check_eq("novl_z4", 32'(z), 32'd1);
    bit_in(1); bit_in(0);
    check_eq("novl_z6", 32'(z), 32'd0);
    check_eq("novl_cnt", 32'(match_cnt), 32'd1);
    bit_in(1); bit_in(0);
    check_eq("novl_z8", 32'(z), 32'd1);

    // en gap inside a match, then z holds through another gap
    ovl_cur = 1'b1;
    load(PAT0);
    bit_in(0); bit_in(0); bit_in(0);
    idle(1); idle(0); idle(1);
    bit_in(1);
    check_eq("gap_z", 32'(z), 32'd1);
    idle(0); idle(1);
    check_eq("gap_hold", 32'(z), 32'd1);

    // Reset mid-stream
    bit_in(0); bit_in(0); bit_in(0);
    step(1'b1, 1'b0, 1'b1, 1'b0, ovl_cur, 4'h0);
    bit_in(1);
    check_eq("rst_mid_z", 32'(z), 32'd0);
    check_eq("rst_mid_fill", 32'(fill), 32'd1);
    bit_in(0); bit_in(0); bit_in(0); bit_in(1);
    check_eq("rst_mid_match", 32'(z), 32'd1);

    // pat_ld wins over en, and clears a standing z
    step(1'b0, 1'b1, 1'b1, 1'b0, ovl_cur, PAT0);
    check_eq("ld_fill", 32'(fill), 32'd0);
    check_eq("ld_cnt", 32'(match_cnt), 32'd0);
    check_eq("ld_z", 32'(z), 32'd0);

    // Saturation on the 2-bit counter
    for (int r = 0; r < 5; r++) begin
      bit_in(0); bit_in(0); bit_in(0); bit_in(1);
      check_eq("sat_z", 32'(z2), 32'd1);
      check_eq("sat_cnt", 32'(match_cnt2), 32'(sat_exp[r]));
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_ld, r_en;
      r_rst = ($urandom % 300) == 0;
      r_ld  = ($urandom % 40) == 0;
      r_en  = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) ovl_cur = ~ovl_cur;
      step(r_rst, r_ld, r_en, 1'($urandom), ovl_cur, N'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
